// File: rtl/uart_rx_frame_if.sv
// Receive-side bundle: serial line in, recovered byte and status strobes out.
interface uart_rx_frame_if;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   modport master (
      input  rx,
      output data_out, data_valid, frame_err, parity_err, busy
   );

   modport slave (
      output rx,
      input  data_out, data_valid, frame_err, parity_err, busy
   );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: start, 8 data bits LSB first, optional even parity (UART_RX_PARITY_EN), one stop.
// Strobes are registered one cycle after the stop sample; no backpressure, the consumer must take each pulse.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic             clk,
   input  logic             reset,
   uart_rx_frame_if.master  bus_if
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, rx_s_q, rx_prev_q;
   logic [1:0]       warm_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       dout_q, dout_d;
   logic             dv_q, dv_d;
   logic             fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
   logic             pe_q, pe_d;
   logic             perr_q, perr_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         warm_q    <= 2'd0;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= 3'd0;
         shift_q   <= 8'hFF;
         dout_q    <= 8'hFF;
         dv_q      <= 1'b0;
         fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_q      <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         sync1_q   <= bus_if.rx;
         rx_s_q    <= sync1_q;
         rx_prev_q <= rx_s_q;
         // The synchronizer's reset-time 1s are not a real line level; wait until rx_prev reflects the pin.
         if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         dout_q    <= dout_d;
         dv_q      <= dv_d;
         fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
         pe_q      <= pe_d;
         perr_q    <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d    = 1'b0;
      perr_d  = perr_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (warm_q == 2'd3 && rx_prev_q && !rx_s_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               perr_d  = rx_s_q ^ (^shift_q);
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // Leave mid-stop-bit so a start edge right at the end of the stop bit is caught.
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               fe_d    = !rx_s_q;
`ifdef UART_RX_PARITY_EN
               pe_d    = perr_q;
               if (rx_s_q && !perr_q) begin
`else
               if (rx_s_q) begin
`endif
                  dout_d = shift_q;
                  dv_d   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus_if.data_out   = dout_q;
   assign bus_if.data_valid = dv_q;
   assign bus_if.frame_err  = fe_q;
`ifdef UART_RX_PARITY_EN
   assign bus_if.parity_err = pe_q;
`else
   assign bus_if.parity_err = 1'b0;
`endif
   assign bus_if.busy       = (state_q != S_IDLE);

endmodule
